// File: rtl/branch_target_table.sv
// Branch-target table: 2^A entries of D bits with valid flags, one-cycle registered lookup
// (absolute, PC-relative or fall-through), a write port with write-first bypass, and a flush sweep.
module branch_target_table #(
    parameter int D = 10,
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    input  logic [A-1:0] req_addr,
    input  logic         req_rel,
    input  logic [D-1:0] req_pc,
    output logic         rsp_valid,
    output logic [D-1:0] rsp_target,
    output logic         rsp_miss,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    input  logic         flush,
    output logic         busy
);

    localparam int          DEPTH    = 1 << A;
    localparam logic [A-1:0] LAST_IDX = A'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t       state_reg;
    logic [A-1:0] idx_reg;
    logic         busy_reg;

    logic [D-1:0] entry_word [DEPTH];
    logic         valid_word [DEPTH];

    logic         clear_en;
    logic         wr_accept;

    logic         lookup_hit;
    logic [D-1:0] lookup_data;
    logic [D-1:0] target_next;

    logic         rsp_valid_reg;
    logic [D-1:0] rsp_target_reg;
    logic         rsp_miss_reg;

    assign clear_en  = (state_reg == CLEAR);
    // A flush sampled in IDLE takes priority over a same-cycle write.
    assign wr_accept = (state_reg == IDLE) && wr_en && !flush;

    // Sweep controller: idx walks every entry once, then wraps back to 0 on exit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (flush) begin
                        state_reg <= CLEAR;
                        busy_reg  <= 1'b1;
                        idx_reg   <= '0;
                    end
                end
                CLEAR: begin
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Each entry is its own register so the whole table clears on reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [D-1:0] data_reg;
            logic         valid_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (clear_en && (idx_reg == A'(gi))) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (wr_accept && (wr_addr == A'(gi))) begin
                    data_reg  <= wr_data;
                    valid_reg <= 1'b1;
                end
            end

            assign entry_word[gi] = data_reg;
            assign valid_word[gi] = valid_reg;
        end
    endgenerate

    // Lookup against the table as it stands this cycle; same-index write wins (write-first).
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        if (state_reg == IDLE) begin
            if (wr_en && (wr_addr == req_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = wr_data;
            end else if (valid_word[req_addr]) begin
                lookup_hit  = 1'b1;
                lookup_data = entry_word[req_addr];
            end
        end
    end

    always_comb begin
        target_next = req_pc + D'(1);
        if (lookup_hit) begin
            target_next = req_rel ? (req_pc + lookup_data) : lookup_data;
        end
    end

    // Target and miss hold their last values on cycles without a request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_reg  <= 1'b0;
            rsp_target_reg <= '0;
            rsp_miss_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= req_valid;
            if (req_valid) begin
                rsp_target_reg <= target_next;
                rsp_miss_reg   <= !lookup_hit;
            end
        end
    end

    assign rsp_valid  = rsp_valid_reg;
    assign rsp_target = rsp_target_reg;
    assign rsp_miss   = rsp_miss_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_branch_target_table.sv
// Scoreboard bench for branch_target_table: directed scenarios then random traffic,
// checked against a countdown-based table model.
module tb_branch_target_table;

    localparam int D     = 10;
    localparam int A     = 4;
    localparam int DEPTH = 1 << A;

    logic         clk;
    logic         reset_n;
    logic         req_valid;
    logic [A-1:0] req_addr;
    logic         req_rel;
    logic [D-1:0] req_pc;
    logic         rsp_valid;
    logic [D-1:0] rsp_target;
    logic         rsp_miss;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_data;
    logic         flush;
    logic         busy;

    branch_target_table #(.D(D), .A(A)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_rel   (req_rel),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_target(rsp_target),
        .rsp_miss  (rsp_miss),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .flush     (flush),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [D-1:0] target;
        logic         miss;
    } rsp_t;

    typedef struct packed {
        logic valid;
        logic busy;
    } cyc_t;

    rsp_t rsp_q [$];
    cyc_t cyc_q [$];

    int checks = 0;
    int errors = 0;

    // Reference model: the sweep is a countdown of cycles left, not an index register.
    int           clear_left = 0;
    int           model_val [DEPTH];
    bit           model_vld [DEPTH];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        clear_left = 0;
        for (int i = 0; i < DEPTH; i++) begin
            model_val[i] = 0;
            model_vld[i] = 1'b0;
        end
    endtask

    // One clock of stimulus: drive, predict, then advance the model past the edge.
    task automatic drive(input bit rv, input int ra, input bit rr, input int rp,
                         input bit we, input int wa, input int wd, input bit fl);
        rsp_t r;
        cyc_t c;
        int   data;
        bit   hit;
        @(negedge clk);
        req_valid = rv;
        req_addr  = A'(ra);
        req_rel   = rr;
        req_pc    = D'(rp);
        wr_en     = we;
        wr_addr   = A'(wa);
        wr_data   = D'(wd);
        flush     = fl;

        hit  = 1'b0;
        data = 0;
        if (clear_left == 0) begin
            if (we && wa == ra) begin
                hit  = 1'b1;
                data = wd;
            end else if (model_vld[ra]) begin
                hit  = 1'b1;
                data = model_val[ra];
            end
        end
        if (rv) begin
            r.miss   = !hit;
            r.target = !hit ? D'((rp + 1) % (1 << D))
                            : (rr ? D'((rp + data) % (1 << D)) : D'(data));
            rsp_q.push_back(r);
        end

        if (clear_left > 0) begin
            model_val[DEPTH - clear_left] = 0;
            model_vld[DEPTH - clear_left] = 1'b0;
            clear_left--;
        end else if (fl) begin
            clear_left = DEPTH;
        end else if (we) begin
            model_val[wa] = wd;
            model_vld[wa] = 1'b1;
        end

        c.valid = rv;
        c.busy  = (clear_left > 0);
        cyc_q.push_back(c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    logic [D-1:0] last_target;
    logic         last_miss;
    always begin
        cyc_t c;
        rsp_t r;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            last_target = '0;
            last_miss   = 1'b0;
        end else if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            chk("rsp_valid", int'(rsp_valid), int'(c.valid));
            chk("busy", int'(busy), int'(c.busy));
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_target", int'(rsp_target), int'(r.target));
                    chk("rsp_miss", int'(rsp_miss), int'(r.miss));
                    last_target = r.target;
                    last_miss   = r.miss;
                end
            end else begin
                chk("hold_target", int'(rsp_target), int'(last_target));
                chk("hold_miss", int'(rsp_miss), int'(last_miss));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_rel   = 1'b0;
        req_pc    = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        flush     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_target", int'(rsp_target), 0);
        chk("reset_rsp_miss", int'(rsp_miss), 0);
        chk("reset_busy", int'(busy), 0);
        reset_n = 1'b1;

        // Misses after reset, including PC wrap.
        drive(1, 3, 0, 100, 0, 0, 0, 0);
        drive(1, 3, 0, 1023, 0, 0, 0, 0);
        // Absolute hits, then idle hold.
        drive(0, 0, 0, 0, 1, 2, 41, 0);
        drive(0, 0, 0, 0, 1, 7, 97, 0);
        drive(1, 2, 0, 0, 0, 0, 0, 0);
        drive(1, 7, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Relative mode with wrap in both directions.
        drive(0, 0, 0, 0, 1, 1, 10'h3FB, 0);
        drive(0, 0, 0, 0, 1, 4, 20, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 1, 4, 0, 0, 0, 0);
        drive(1, 4, 1, 1020, 0, 0, 0, 0);
        drive(1, 0, 1, 55, 0, 0, 0, 0);
        // Write-first bypass on an invalid entry.
        drive(1, 5, 0, 300, 1, 5, 87, 0);
        drive(1, 5, 1, 300, 0, 0, 0, 0);
        // Flush sweep with write and request during busy.
        drive(1, 2, 0, 10, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 9, 72, 0);
        drive(1, 2, 0, 200, 0, 0, 0, 0);
        idle(DEPTH);
        drive(1, 2, 0, 7, 0, 0, 0, 0);
        drive(1, 9, 0, 8, 0, 0, 0, 0);
        // Async reset mid-sweep.
        drive(0, 0, 0, 0, 1, 3, 33, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);
        drive(1, 3, 0, 500, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_rsp_valid", int'(rsp_valid), 0);
        req_valid = 1'b0;
        flush     = 1'b0;
        wr_en     = 1'b0;
        cyc_q.delete();
        rsp_q.delete();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 3, 0, 600, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 6, 66, 1);
        idle(DEPTH + 1);
        drive(1, 6, 0, 1, 0, 0, 0, 0);

        // Random traffic; a narrow address range makes bypass collisions common.
        for (int i = 0; i < 600; i++) begin
            int ra, wa;
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            ra = narrow ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1));
            wa = narrow ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1));
            drive($urandom_range(0, 9) < 7, ra, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, (1 << D) - 1)),
                  $urandom_range(0, 9) < 4, wa, int'($urandom_range(0, (1 << D) - 1)),
                  $urandom_range(0, 99) < 2);
        end
        idle(2);
        @(negedge clk);
        chk("rsp_queue_drained", rsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
